// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_muldiv_pkg : opcodes, result classes and iterative-unit states |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package ex_muldiv_pkg;

  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  typedef logic [ALUOP_W-1:0]  aluop_t;
  typedef logic [ALUSEL_W-1:0] alusel_t;

  localparam aluop_t EXE_NOP_OP   = 8'd0;
  localparam aluop_t EXE_OR_OP    = 8'd1;
  localparam aluop_t EXE_AND_OP   = 8'd2;
  localparam aluop_t EXE_XOR_OP   = 8'd3;
  localparam aluop_t EXE_NOR_OP   = 8'd4;
  localparam aluop_t EXE_SLL_OP   = 8'd5;
  localparam aluop_t EXE_SRL_OP   = 8'd6;
  localparam aluop_t EXE_SRA_OP   = 8'd7;
  localparam aluop_t EXE_ADD_OP   = 8'd8;
  localparam aluop_t EXE_SUB_OP   = 8'd9;
  localparam aluop_t EXE_SLT_OP   = 8'd10;
  localparam aluop_t EXE_SLTU_OP  = 8'd11;
  localparam aluop_t EXE_MULT_OP  = 8'd12;
  localparam aluop_t EXE_MULTU_OP = 8'd13;
  localparam aluop_t EXE_DIV_OP   = 8'd14;
  localparam aluop_t EXE_DIVU_OP  = 8'd15;
  localparam aluop_t EXE_MFHI_OP  = 8'd16;
  localparam aluop_t EXE_MFLO_OP  = 8'd17;
  localparam aluop_t EXE_MTHI_OP  = 8'd18;
  localparam aluop_t EXE_MTLO_OP  = 8'd19;

  localparam alusel_t EXE_RES_NOP   = 3'd0;
  localparam alusel_t EXE_RES_LOGIC = 3'd1;
  localparam alusel_t EXE_RES_SHIFT = 3'd2;
  localparam alusel_t EXE_RES_ARITH = 3'd3;
  localparam alusel_t EXE_RES_MOVE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input aluop_t op);
    return op inside {EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_muldiv_if : id_ex -> execute -> ex_mem signal bundle           |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  aluop_t                aluop_i;
  alusel_t               alusel_i;
  logic [DATA_W-1:0]     reg1_i;
  logic [DATA_W-1:0]     reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic                  flush_i;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [DATA_W-1:0]     wdata_o;
  logic                  stall_req_o;
  logic [DATA_W-1:0]     hi_o;
  logic [DATA_W-1:0]     lo_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_muldiv_iter : bit-serial multiply / restoring divide unit      |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module ex_muldiv_iter
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  aluop_t            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int               CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  md_state_t           state, state_nxt;
  logic [CNT_W-1:0]    count;
  logic                op_mul, op_div, op_signed, b_zero, start;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic                is_mul, div_zero, neg_q, neg_r;
  logic [DATA_W:0]     work_hi, add_sum, shifted, diff;
  logic [DATA_W-1:0]   work_lo, operand;
  logic [2*DATA_W-1:0] prod_mag;

  assign op_mul    = (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
  assign op_div    = (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  assign op_signed = (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
  assign b_zero    = (b == '0);
  assign start     = (state == ST_IDLE) && (op_mul || op_div) && !flush;
  // Unsigned magnitude: the most-negative value maps to 2^(DATA_W-1) exactly.
  assign mag_a     = (op_signed && a[DATA_W-1]) ? -a : a;
  assign mag_b     = (op_signed && b[DATA_W-1]) ? -b : b;

  // work_hi carries one spare bit: multiply carry-out / divide borrow.
  assign add_sum = work_hi + {1'b0, operand};
  assign shifted = {work_hi[DATA_W-1:0], work_lo[DATA_W-1]};
  assign diff    = shifted - {1'b0, operand};

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          state_nxt = (op_div && b_zero) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        stall_req = 1'b1;
        if (count == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      stall_req = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      is_mul   <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      work_hi  <= '0;
      work_lo  <= '0;
      operand  <= '0;
    end else if (start) begin
      count    <= '0;
      is_mul   <= op_mul;
      div_zero <= op_div && b_zero;
      neg_q    <= op_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r    <= op_signed && a[DATA_W-1];
      work_hi  <= '0;
      work_lo  <= op_mul ? mag_b : (b_zero ? a : mag_a);
      operand  <= op_mul ? mag_a : mag_b;
    end else if (state == ST_RUN) begin
      count <= count + CNT_W'(1);
      if (is_mul) begin
        {work_hi, work_lo} <= {1'b0, (work_lo[0] ? add_sum : work_hi), work_lo[DATA_W-1:1]};
      end else if (!diff[DATA_W]) begin
        work_hi <= diff;
        work_lo <= {work_lo[DATA_W-2:0], 1'b1};
      end else begin
        work_hi <= shifted;
        work_lo <= {work_lo[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod_mag = {work_hi[DATA_W-1:0], work_lo};
    hi       = '0;
    lo       = '0;
    if (div_zero) begin
      hi = work_lo;
      lo = '1;
    end else if (is_mul) begin
      {hi, lo} = neg_q ? -prod_mag : prod_mag;
    end else begin
      lo = neg_q ? -work_lo : work_lo;
      hi = neg_r ? -work_hi[DATA_W-1:0] : work_hi[DATA_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_muldiv : execute stage with ALU, HI/LO and iterative mul/div   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SH_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  aluop_t            op;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] logic_res, shift_res, arith_res, move_res;
  logic [DATA_W-1:0] sum, dif;
  logic [SH_W-1:0]   sa;
  logic              add_ovf, sub_ovf, overflow;
  logic              md_stall, md_done;
  logic [DATA_W-1:0] md_hi, md_lo;

  assign op = bus.aluop_i;
  assign sa = bus.reg1_i[SH_W-1:0];

  ex_muldiv_iter #(.DATA_W(DATA_W)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .op        (bus.aluop_i),
    .a         (bus.reg1_i),
    .b         (bus.reg2_i),
    .flush     (bus.flush_i),
    .stall_req (md_stall),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  always_comb begin
    sum      = bus.reg1_i + bus.reg2_i;
    dif      = bus.reg1_i - bus.reg2_i;
    add_ovf  = (bus.reg1_i[DATA_W-1] == bus.reg2_i[DATA_W-1]) && (sum[DATA_W-1] != bus.reg1_i[DATA_W-1]);
    sub_ovf  = (bus.reg1_i[DATA_W-1] != bus.reg2_i[DATA_W-1]) && (dif[DATA_W-1] != bus.reg1_i[DATA_W-1]);
    overflow = ((op == EXE_ADD_OP) && add_ovf) || ((op == EXE_SUB_OP) && sub_ovf);

    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    move_res  = '0;
    case (op)
      EXE_OR_OP:   logic_res = bus.reg1_i | bus.reg2_i;
      EXE_AND_OP:  logic_res = bus.reg1_i & bus.reg2_i;
      EXE_XOR_OP:  logic_res = bus.reg1_i ^ bus.reg2_i;
      EXE_NOR_OP:  logic_res = ~(bus.reg1_i | bus.reg2_i);
      EXE_SLL_OP:  shift_res = bus.reg2_i << sa;
      EXE_SRL_OP:  shift_res = bus.reg2_i >> sa;
      EXE_SRA_OP:  shift_res = $signed(bus.reg2_i) >>> sa;
      EXE_ADD_OP:  arith_res = sum;
      EXE_SUB_OP:  arith_res = dif;
      EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(bus.reg1_i) < $signed(bus.reg2_i))};
      EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, (bus.reg1_i < bus.reg2_i)};
      EXE_MFHI_OP: move_res  = hi_q;
      EXE_MFLO_OP: move_res  = lo_q;
      default:     ;
    endcase

    bus.wdata_o = '0;
    if (rst) begin
      case (bus.alusel_i)
        EXE_RES_LOGIC: bus.wdata_o = logic_res;
        EXE_RES_SHIFT: bus.wdata_o = shift_res;
        EXE_RES_ARITH: bus.wdata_o = arith_res;
        EXE_RES_MOVE:  bus.wdata_o = move_res;
        default:       bus.wdata_o = '0;
      endcase
    end
    bus.wd_o        = rst ? bus.wd_i : {REG_ADDR_W{1'b0}};
    bus.wreg_o      = rst && bus.wreg_i && !is_muldiv(op) && (op != EXE_MTHI_OP)
                      && (op != EXE_MTLO_OP) && !overflow;
    bus.stall_req_o = rst && md_stall;
  end

  // A flushed instruction must not touch HI/LO, whether it is a move or a completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (!bus.flush_i && (op == EXE_MTHI_OP)) begin
      hi_q <= bus.reg1_i;
    end else if (!bus.flush_i && (op == EXE_MTLO_OP)) begin
      lo_q <= bus.reg1_i;
    end
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ex_muldiv : scoreboard bench for ex_muldiv                     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.DATA_W(W), .REG_ADDR_W(5)) bus ();
  ex_muldiv #(.DATA_W(W), .REG_ADDR_W(5), .SH_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]   wd;
    logic         wreg;
    logic [W-1:0] wdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  logic         tb_valid = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic predict(input aluop_t op, input alusel_t sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] wd, input logic wr,
                         output exp_t e, output int stall);
    longint      sa, sb, t, q, r;
    logic [63:0] p;
    bit          ovf, md;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 0;
    md  = op inside {EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
    e.wd = wd; e.hi = m_hi; e.lo = m_lo; e.wdata = '0;
    stall = 0;
    if (op == EXE_ADD_OP) begin t = sa + sb; ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
    if (op == EXE_SUB_OP) begin t = sa - sb; ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
    case (sel)
      EXE_RES_LOGIC: case (op)
        EXE_OR_OP:  e.wdata = a | b;
        EXE_AND_OP: e.wdata = a & b;
        EXE_XOR_OP: e.wdata = a ^ b;
        EXE_NOR_OP: e.wdata = ~(a | b);
        default:    e.wdata = '0;
      endcase
      EXE_RES_SHIFT: case (op)
        EXE_SLL_OP: e.wdata = b << a[4:0];
        EXE_SRL_OP: e.wdata = b >> a[4:0];
        EXE_SRA_OP: begin t = sb >>> a[4:0]; e.wdata = t[31:0]; end
        default:    e.wdata = '0;
      endcase
      EXE_RES_ARITH: case (op)
        EXE_ADD_OP:  e.wdata = a + b;
        EXE_SUB_OP:  e.wdata = a - b;
        EXE_SLT_OP:  e.wdata = (sa < sb) ? 32'd1 : 32'd0;
        EXE_SLTU_OP: e.wdata = (a < b) ? 32'd1 : 32'd0;
        default:     e.wdata = '0;
      endcase
      EXE_RES_MOVE: case (op)
        EXE_MFHI_OP: e.wdata = m_hi;
        EXE_MFLO_OP: e.wdata = m_lo;
        default:     e.wdata = '0;
      endcase
      default: e.wdata = '0;
    endcase
    e.wreg = wr && !md && (op != EXE_MTHI_OP) && (op != EXE_MTLO_OP) && !ovf;
    case (op)
      EXE_MTHI_OP: m_hi = a;
      EXE_MTLO_OP: m_lo = a;
      EXE_MULT_OP: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; stall = W + 1; end
      EXE_MULTU_OP: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; stall = W + 1; end
      EXE_DIV_OP: begin
        if (b == 0) begin m_hi = a; m_lo = '1; stall = 1; end
        else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; stall = W + 1; end
      end
      EXE_DIVU_OP: begin
        if (b == 0) begin m_hi = a; m_lo = '1; stall = 1; end
        else begin m_lo = a / b; m_hi = a % b; stall = W + 1; end
      end
      default: ;
    endcase
  endtask

  task automatic drive_op(input aluop_t op, input alusel_t sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] wd, input logic wr);
    exp_t e;
    int   exp_stall, n;
    predict(op, sel, a, b, wd, wr, e, exp_stall);
    exp_q.push_back(e);
    bus.aluop_i = op; bus.alusel_i = sel; bus.reg1_i = a; bus.reg2_i = b;
    bus.wd_i = wd; bus.wreg_i = wr; tb_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.stall_req_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 64'(n), 64'(exp_stall));
    @(posedge clk); #1;
    tb_valid = 1'b0;
    bus.aluop_i = EXE_NOP_OP; bus.alusel_i = EXE_RES_NOP; bus.wreg_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && tb_valid && bus.stall_req_o === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wd_o",    64'(bus.wd_o),    64'(mon_e.wd));
        chk("wreg_o",  64'(bus.wreg_o),  64'(mon_e.wreg));
        chk("wdata_o", 64'(bus.wdata_o), 64'(mon_e.wdata));
        chk("hi_o",    64'(bus.hi_o),    64'(mon_e.hi));
        chk("lo_o",    64'(bus.lo_o),    64'(mon_e.lo));
      end
    end
  end

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic pick(input int k, output aluop_t op, output alusel_t sel);
    sel = EXE_RES_NOP;
    case (k)
      0:  begin op = EXE_OR_OP;  sel = EXE_RES_LOGIC; end
      1:  begin op = EXE_AND_OP; sel = EXE_RES_LOGIC; end
      2:  begin op = EXE_XOR_OP; sel = EXE_RES_LOGIC; end
      3:  begin op = EXE_NOR_OP; sel = EXE_RES_LOGIC; end
      4:  begin op = EXE_SLL_OP; sel = EXE_RES_SHIFT; end
      5:  begin op = EXE_SRL_OP; sel = EXE_RES_SHIFT; end
      6:  begin op = EXE_SRA_OP; sel = EXE_RES_SHIFT; end
      7:  begin op = EXE_ADD_OP; sel = EXE_RES_ARITH; end
      8:  begin op = EXE_SUB_OP; sel = EXE_RES_ARITH; end
      9:  begin op = EXE_SLT_OP; sel = EXE_RES_ARITH; end
      10: begin op = EXE_SLTU_OP; sel = EXE_RES_ARITH; end
      11: op = EXE_MULT_OP;
      12: op = EXE_MULTU_OP;
      13: op = EXE_DIV_OP;
      14: op = EXE_DIVU_OP;
      15: begin op = EXE_MFHI_OP; sel = EXE_RES_MOVE; end
      16: begin op = EXE_MFLO_OP; sel = EXE_RES_MOVE; end
      17: op = EXE_MTHI_OP;
      default: op = EXE_MTLO_OP;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "time limit");
  end

  initial begin
    aluop_t  rop;
    alusel_t rsel;
    int      k;
    rst = 1'b0;
    bus.aluop_i = EXE_OR_OP; bus.alusel_i = EXE_RES_LOGIC;
    bus.reg1_i = 32'h1; bus.reg2_i = 32'h2; bus.wd_i = 5'd5; bus.wreg_i = 1'b1; bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wd_o", 64'(bus.wd_o), 64'd0);
    chk("rst_wreg_o", 64'(bus.wreg_o), 64'd0);
    chk("rst_wdata_o", 64'(bus.wdata_o), 64'd0);
    chk("rst_stall", 64'(bus.stall_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; bus.aluop_i = EXE_NOP_OP; bus.alusel_i = EXE_RES_NOP; bus.wreg_i = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_lo", 64'(bus.lo_o), 64'd0);
    @(posedge clk); #1;

    drive_op(EXE_OR_OP,  EXE_RES_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 5'd1, 1'b1);
    drive_op(EXE_OR_OP,  3'd7,          32'h0F0F_0000, 32'h0000_00FF, 5'd2, 1'b1);
    drive_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd3, 1'b1);
    drive_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd0, 32'h8000_0000, 5'd3, 1'b1);
    drive_op(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h1, 5'd4, 1'b1);
    drive_op(EXE_SUB_OP, EXE_RES_ARITH, 32'h8000_0000, 32'h1, 5'd4, 1'b1);
    drive_op(EXE_MULT_OP, EXE_RES_NOP, -32'sd3, 32'd5, 5'd0, 1'b1);
    drive_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
    drive_op(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
    drive_op(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd7, 1'b1);
    drive_op(EXE_DIV_OP, EXE_RES_NOP, -32'sd7, 32'd2, 5'd0, 1'b0);
    drive_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd9, 32'd0, 5'd0, 1'b0);
    drive_op(EXE_DIV_OP, EXE_RES_NOP, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);

    // Flush in the middle of a divide: stall drops at once and HI/LO keep MTHI's value.
    drive_op(EXE_MTHI_OP, EXE_RES_NOP, 32'h1234, 32'd0, 5'd0, 1'b1);
    bus.aluop_i = EXE_DIVU_OP; bus.reg1_i = 32'd100; bus.reg2_i = 32'd7;
    repeat (10) @(posedge clk);
    #1 chk("run_stall", 64'(bus.stall_req_o), 64'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(bus.stall_req_o), 64'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.aluop_i = EXE_NOP_OP;
    drive_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd8, 1'b1);

    // Flush landing on the completion cycle suppresses the HI/LO write.
    bus.aluop_i = EXE_MULT_OP; bus.reg1_i = 32'h0001_0000; bus.reg2_i = 32'h0001_0000;
    repeat (W + 1) @(posedge clk);
    #1 chk("done_stall", 64'(bus.stall_req_o), 64'd0);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.aluop_i = EXE_NOP_OP;
    drive_op(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd9, 1'b1);

    // Reset mid-multiply.
    bus.aluop_i = EXE_MULT_OP; bus.reg1_i = 32'd7; bus.reg2_i = 32'd9;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_run_stall", 64'(bus.stall_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; bus.aluop_i = EXE_NOP_OP;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("rst_run_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_run_lo", 64'(bus.lo_o), 64'd0);
    chk("rst_idle_stall", 64'(bus.stall_req_o), 64'd0);
    @(posedge clk); #1;
    drive_op(EXE_MULT_OP, EXE_RES_NOP, 32'd2, 32'd3, 5'd0, 1'b0);
    drive_op(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd10, 1'b1);

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 18);
      pick(k, rop, rsel);
      drive_op(rop, rsel, rand_val(), rand_val(), 5'($urandom), 1'($urandom));
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
